// File: rtl/bus_router.sv
// Memory-bus router between the picorv32 native interface and up to 16 slaves.
// Decodes a region index, steers strobes, generates or forwards ready, and logs errors.
module bus_router #(
  parameter int                    NUM_SLAVES = 8,
  parameter int                    SEL_LSB    = 16,
  parameter int                    SEL_BITS   = 4,
  parameter logic [NUM_SLAVES-1:0] SYNC_MASK  = '1,
  parameter int                    TIMEOUT    = 255,
  parameter logic [31:0]           ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  input  logic [3:0]              m_wstrb,
  output logic [31:0]             m_rdata,
  output logic [NUM_SLAVES-1:0]   s_sel,
  output logic [4*NUM_SLAVES-1:0] s_wstrb,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  input  logic                    err_clr,
  output logic                    err_irq,
  output logic [31:0]             err_addr,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t              state, state_next;
  logic [7:0]          cnt, cnt_next;
  logic [SEL_BITS-1:0] idx;
  logic                mapped, req;
  logic                is_sync, sel_ready;
  logic [31:0]         sel_rdata;
  logic                normal_hit, resp_ok, resp_err;

  // Slaves take write data straight from the CPU bus; the router never looks at it.
  logic unused_wdata;
  assign unused_wdata = ^m_wdata;

  assign idx    = m_addr[SEL_LSB +: SEL_BITS];
  assign mapped = int'(idx) < NUM_SLAVES;
  // A request is live only outside DONE, so the guaranteed idle cycle masks m_valid.
  assign req    = !rst && m_valid && (state != DONE);

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    is_sync   = 1'b0;
    s_sel     = '0;
    s_wstrb   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx) == i) begin
        sel_rdata = s_rdata[32*i +: 32];
        sel_ready = s_ready[i];
        is_sync   = SYNC_MASK[i];
        s_sel[i]  = req;
        if (req) s_wstrb[4*i +: 4] = m_wstrb;
      end
    end
  end

  assign normal_hit = mapped && (is_sync ? (cnt == 8'd1) : sel_ready);
  assign resp_ok    = req && normal_hit;
  assign resp_err   = req && ((mapped && !normal_hit && cnt == TIMEOUT_CNT) ||
                              (!mapped && cnt == 8'd1));
  assign m_ready    = resp_ok || resp_err;
  assign m_rdata    = resp_err ? ERR_DATA : (resp_ok ? sel_rdata : 32'h0);

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (m_ready) begin
            state_next = DONE;
          end else begin
            state_next = ACCESS;
            cnt_next   = cnt + 8'd1;
          end
        end
      end
      ACCESS: begin
        // Master withdrew the request: abandon without a response.
        if (!req)         state_next = IDLE;
        else if (m_ready) state_next = DONE;
        else              cnt_next   = cnt + 8'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err_irq   <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      err_irq <= resp_err;
      if (resp_err) err_addr <= m_addr;
      // Clear has priority over a coincident error.
      if (err_clr)
        err_count <= '0;
      else if (resp_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_router.sv
// Scoreboard bench for bus_router: expected responses are queued when an
// access is issued and popped when m_ready is observed.
module tb_bus_router;

  localparam int          NS  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_rdata;
  logic [NS-1:0]     s_sel;
  logic [4*NS-1:0]   s_wstrb;
  logic [32*NS-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;
  logic              err_clr;
  logic              err_irq;
  logic [31:0]       err_addr;
  logic [7:0]        err_count;

  always #5 clk = ~clk;

  bus_router #(
    .NUM_SLAVES(NS), .SEL_LSB(16), .SEL_BITS(4),
    .SYNC_MASK(8'hF7), .TIMEOUT(10), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
    .err_clr(err_clr), .err_irq(err_irq), .err_addr(err_addr), .err_count(err_count)
  );

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          exp_errs = 0;
  logic [31:0] exp_err_addr = '0;

  // One full access: issue at a negedge, wait (bounded) for m_ready, then
  // check the DONE cycle with m_valid still held high.
  task automatic run_access(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input int rdy_at,
                            input int lat, input logic [31:0] rdata,
                            input logic err, input logic clr);
    exp_t          e;
    int            idx;
    logic [NS-1:0] esel;
    logic [4*NS-1:0] ewstrb;
    bit            seen;
    idx    = int'(addr[19:16]);
    esel   = '0;
    ewstrb = '0;
    if (idx < NS) begin
      esel[idx]          = 1'b1;
      ewstrb[4*idx +: 4] = wstrb;
    end
    e.rdata = rdata; e.lat = lat; e.err = err;
    sb.push_back(e);
    @(negedge clk);
    m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata;
    seen = 1'b0;
    for (int c = 0; c <= 300 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      if (rdy_at >= 0 && c >= rdy_at && idx < NS) s_ready[idx] = 1'b1;
      #1;
      chk_cnt++;
      if (s_sel !== esel) $display("FAIL s_sel @%h cyc %0d: got %h want %h", addr, c, s_sel, esel);
      else pass_cnt++;
      chk_cnt++;
      if (s_wstrb !== ewstrb) $display("FAIL s_wstrb @%h cyc %0d: got %h want %h", addr, c, s_wstrb, ewstrb);
      else pass_cnt++;
      if (m_ready === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk_cnt++;
        if (c !== e.lat) $display("FAIL latency @%h: got %0d want %0d", addr, c, e.lat);
        else pass_cnt++;
        chk_cnt++;
        if (m_rdata !== e.rdata) $display("FAIL m_rdata @%h: got %h want %h", addr, m_rdata, e.rdata);
        else pass_cnt++;
        if (clr) err_clr = 1'b1;
      end else begin
        chk_cnt++;
        if (m_rdata !== 32'h0) $display("FAIL idle_rdata @%h cyc %0d: got %h want 0", addr, c, m_rdata);
        else pass_cnt++;
      end
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL ready_timeout @%h: no m_ready within 300 cycles, want at %0d", addr, lat);
      e = sb.pop_front();
    end
    if (clr) exp_errs = 0;
    else if (err && exp_errs < 255) exp_errs++;
    if (err) exp_err_addr = addr;
    @(negedge clk);
    err_clr = 1'b0;
    s_ready = '0;
    #1;
    chk_cnt++;
    if (s_sel !== '0 || s_wstrb !== '0 || m_ready !== 1'b0)
      $display("FAIL done_quiet @%h: sel %h wstrb %h ready %b want 0", addr, s_sel, s_wstrb, m_ready);
    else pass_cnt++;
    chk_cnt++;
    if (err_irq !== err) $display("FAIL err_irq @%h: got %b want %b", addr, err_irq, err);
    else pass_cnt++;
    chk_cnt++;
    if (err_count !== 8'(exp_errs)) $display("FAIL err_count @%h: got %0d want %0d", addr, err_count, exp_errs);
    else pass_cnt++;
    chk_cnt++;
    if (err_addr !== exp_err_addr) $display("FAIL err_addr @%h: got %h want %h", addr, err_addr, exp_err_addr);
    else pass_cnt++;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_valid = 1'b1; m_addr = 32'h0001_0000; m_wstrb = 4'hF;
    m_wdata = 32'h0; err_clr = 1'b0; s_ready = '1;
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = 32'h3333_0000 | 32'(i);
    s_rdata[32*1 +: 32] = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk_cnt++;
      if (m_ready !== 1'b0 || s_sel !== '0 || s_wstrb !== '0 || m_rdata !== 32'h0)
        $display("FAIL reset_comb cyc %0d: ready %b sel %h wstrb %h rdata %h want 0", c, m_ready, s_sel, s_wstrb, m_rdata);
      else pass_cnt++;
    end
    chk_cnt++;
    if (err_irq !== 1'b0 || err_addr !== 32'h0 || err_count !== 8'h0)
      $display("FAIL reset_regs: irq %b addr %h count %0d want 0", err_irq, err_addr, err_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; m_valid = 1'b0; s_ready = '0;
  endtask

  task automatic test_sync_read();
    run_access(32'h0001_0004, 4'h0, 32'h0, -1, 1, 32'h1234_5678, 1'b0, 1'b0);
  endtask

  task automatic test_handshake();
    run_access(32'h0003_0000, 4'b0001, 32'hA5, 5, 5, 32'h3333_0003, 1'b0, 1'b0);
    run_access(32'h0003_0008, 4'h0, 32'h0, 0, 0, 32'h3333_0003, 1'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    run_access(32'h000F_0000, 4'h0, 32'h0, -1, 1, ERR, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    run_access(32'h0003_0010, 4'b1111, 32'h55, -1, 10, ERR, 1'b1, 1'b0);
    // Issued at T+12: must find the router idle and complete with normal latency.
    run_access(32'h0002_0000, 4'h0, 32'h0, -1, 1, 32'h3333_0002, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 256; n++)
      run_access(32'h0008_0000 + 32'(n * 4), 4'h0, 32'h0, -1, 1, ERR, 1'b1, 1'b0);
    chk_cnt++;
    if (err_count !== 8'd255) $display("FAIL saturate: got %0d want 255", err_count);
    else pass_cnt++;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; #1;
    exp_errs = 0;
    chk_cnt++;
    if (err_count !== 8'd0) $display("FAIL err_clr: got %0d want 0", err_count);
    else pass_cnt++;
    run_access(32'h0009_0000, 4'h0, 32'h0, -1, 1, ERR, 1'b1, 1'b1);
    run_access(32'h000A_0000, 4'h0, 32'h0, -1, 1, ERR, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0003_0000; m_wstrb = 4'h0; s_ready = '0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) rst = 1'b1;
      #1;
      chk_cnt++;
      if (m_ready !== 1'b0) $display("FAIL reset_mid_ready cyc %0d: got %b want 0", c, m_ready);
      else pass_cnt++;
      if (c >= 2) begin
        chk_cnt++;
        if (s_sel !== '0 || s_wstrb !== '0 || m_rdata !== 32'h0)
          $display("FAIL reset_mid_outs cyc %0d: sel %h wstrb %h rdata %h want 0", c, s_sel, s_wstrb, m_rdata);
        else pass_cnt++;
      end
      if (c >= 3) begin
        chk_cnt++;
        if (err_irq !== 1'b0 || err_count !== 8'h0 || err_addr !== 32'h0)
          $display("FAIL reset_mid_regs cyc %0d: irq %b count %0d addr %h want 0", c, err_irq, err_count, err_addr);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    rst = 1'b0; m_valid = 1'b0;
    exp_errs = 0; exp_err_addr = '0;
    run_access(32'h0001_0004, 4'h0, 32'h0, -1, 1, 32'h1234_5678, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sync_read();
    test_handshake();
    test_unmapped();
    test_timeout();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bus_router.md
# bus_router

Parametrised memory-bus router between the picorv32 native memory interface and up to 16 peripheral slaves. It is the successor to the hand-written chip-select and ready/read-data muxing in the SoC top level. It decodes a region index from the address and steers strobes to one slave. It generates ready itself for fixed-latency (synchronous RAM/ROM) slaves and forwards ready from handshaking slaves. It adds what the hand-coded decode lacks: error responses for unmapped regions, a hung-slave timeout, error logging with an interrupt, and a guaranteed idle cycle between accesses.

## Interface
Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16).
- SEL_LSB, 16, LSB of the region-index field in m_addr.
- SEL_BITS, 4, width of the region-index field; 2^SEL_BITS ≥ NUM_SLAVES.
- SYNC_MASK, all ones, NUM_SLAVES bits; bit i=1 means slave i is fixed one-cycle latency and its s_ready[i] is ignored.
- TIMEOUT, 255, maximum cycles an access may wait for ready (2..255).
- ERR_DATA, 32'hDEADBEEF, read data returned on any error response.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- m_valid  in  1  CPU access request.
- m_ready  out  1  access complete, single-cycle pulse.
- m_addr  in  32  CPU byte address.
- m_wdata  in  32  write data, passed through unchanged to all slaves.
- m_wstrb  in  4  byte write strobes; 0 means read.
- m_rdata  out  32  read data.
- s_sel  out  NUM_SLAVES  one-hot slave select.
- s_wstrb  out  4*NUM_SLAVES  per-slave write strobes; slave i uses bits [4i+3:4i].
- s_rdata  in  32*NUM_SLAVES  per-slave read data; slave i uses bits [32i+31:32i].
- s_ready  in  NUM_SLAVES  per-slave ready, used only by handshaking slaves.
- err_clr  in  1  clears err_count.
- err_irq  out  1  one-cycle error interrupt pulse.
- err_addr  out  32  address of the most recent errored access.
- err_count  out  8  number of errors, saturating.

## Operation
- Region index: idx = m_addr[SEL_LSB +: SEL_BITS].
  - idx < NUM_SLAVES: mapped.
  - Otherwise: unmapped.
- State machine:
  - IDLE → ACCESS: taken when m_valid=1.
  - ACCESS → DONE: taken on the cycle m_ready=1.
  - DONE → IDLE: always, after one cycle.
  - ACCESS → IDLE with no response: taken if m_valid drops before m_ready.
- Select and strobes:
  - s_sel[i] = m_valid && idx==i && state∈{IDLE, ACCESS}; this is combinational, so a slave sees the address in the first request cycle.
  - s_wstrb slice i = m_wstrb when s_sel[i], else 0.
  - In DONE, all s_sel and s_wstrb are 0.
- Wait counter cnt (8 bits):
  - Value is 0 in the first request cycle (IDLE with m_valid).
  - Increments by 1 each ACCESS cycle.
  - Clears on return to IDLE.
- m_ready sources (combinational):
  - Synchronous slave (SYNC_MASK[idx]=1): m_ready=1 when cnt==1, i.e. the second request cycle.
  - Handshaking slave: m_ready = s_ready[idx] in any request cycle, including cnt==0.
  - Unmapped: m_ready=1 when cnt==1, flagged as an error.
  - Timeout: a mapped access still without ready at cnt==TIMEOUT gets m_ready=1 in that cycle, flagged as an error.
- m_rdata:
  - Equals s_rdata slice idx for a normal response.
  - Equals ERR_DATA for an error response.
  - Is 0 whenever m_ready=0.
- Error logging, registered on the error-response cycle:
  - err_addr <= m_addr.
  - err_count increments and saturates at 255.
  - err_irq is 1 in the following cycle only.
- err_clr and a simultaneous error: err_clr wins. err_count goes to 0; err_addr and err_irq still update.
- An errored write performs no slave write beyond the strobes already driven during the wait cycles.

## Timing
- Reset values: state=IDLE, cnt=0, err_irq=0, err_addr=0, err_count=0. m_ready, s_sel, s_wstrb and m_rdata are 0 while rst=1.
- Synchronous slave: request at cycle T, m_ready at T+1, DONE at T+2, IDLE at T+3. Back-to-back accesses take at least 3 cycles.
- Handshaking slave with combinational ready: completes in T; DONE at T+1.
- Timeout response arrives at T+TIMEOUT.
- Reset mid-access: the access is abandoned, no m_ready is ever issued for it, and state is IDLE on the cycle after rst deasserts.
- m_valid still high in DONE is ignored. A new access starts only from IDLE.

## Test plan
- Read from sync slave 1 at addr 0x10004 with s_rdata slice 1 = 0x12345678 -> s_sel=0x02 at T; m_ready and m_rdata=0x12345678 at T+1; s_sel=0 at T+2.
- Write 0xA5 with m_wstrb=4'b0001 to slave 3 (handshaking, SYNC_MASK[3]=0), s_ready[3] raised 5 cycles after request -> s_wstrb slice 3 = 4'b0001 for cycles T..T+5; m_ready at T+5; no error.
- Read from unmapped 0xF0000 (NUM_SLAVES=8) -> m_ready at T+1 with m_rdata=0xDEADBEEF; err_irq at T+2; err_addr=0xF0000; err_count=1.
- Handshaking slave never ready, TIMEOUT=10 -> m_ready at T+10 with ERR_DATA; err_count increments; router is back in IDLE at T+12.
- 256 unmapped accesses -> err_count=255 (saturates); pulsing err_clr -> err_count=0; err_clr coinciding with an error -> err_count=0 and err_irq still pulses.
- rst asserted at T+2 during a stalled access -> no m_ready is ever issued; all outputs are 0 during reset; the next access after reset completes normally.
